bus_arbiter: RTL and testbench
==============================

# bus_arbiter

- Shares the SoC slaves between three masters:
  - m0: core data port (execute stage).
  - m1: core instruction-fetch port.
  - m2: JTAG debug memory port.
- Slaves are s0 (rom) and s1 (ram).
- Sits between the core / jtag_top master ports and the rom/ram slave ports in the SoC top.
- Decodes addresses, arbitrates with fixed priority, and stalls the core through `hold_o`.
- Sequences a drained, hazard-free handover of the bus to the debugger and back.

## Interface

Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `HANDOVER_CYCLES`, 2, idle cycles between core ownership and debug ownership (range 1–15).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `m0_addr_i` in `ADDR_W`, `m0_wdata_i` in `DATA_W`, `m0_rdata_o` out `DATA_W`, `m0_req_i` in 1, `m0_we_i` in 1: core data port.
- `m1_addr_i` in `ADDR_W`, `m1_rdata_o` out `DATA_W`: core fetch port; read-only, always requesting.
- `m2_addr_i` in `ADDR_W`, `m2_wdata_i` in `DATA_W`, `m2_rdata_o` out `DATA_W`, `m2_req_i` in 1, `m2_we_i` in 1: debug port.
- `m2_gnt_o` out 1: debug port owns the bus this cycle.
- `s0_addr_o` out `ADDR_W`, `s0_data_o` out `DATA_W`, `s0_data_i` in `DATA_W`, `s0_we_o` out 1: rom.
- `s1_addr_o` out `ADDR_W`, `s1_data_o` out `DATA_W`, `s1_data_i` in `DATA_W`, `s1_we_o` out 1: ram.
- `hold_o` out 1: stall request to the core pipeline.
- `dec_err_o` out 1: one-cycle pulse when a routed access hits an unmapped region.

## Operation

Address decode on `addr[31:28]`:
- 0x0 selects s0.
- 0x1 selects s1.
- Anything else is unmapped: read data is 0, the write is dropped, `dec_err_o` = 1 that cycle.

Routing:
- At most one master is routed per cycle.
- The routed master's addr and wdata are driven to both slaves.
- Only the selected slave's `we_o` = routed `we` (for m1, we = 0).
- The routed master's `rdata` = selected slave's `data_i`.
- Non-routed masters read 0.

Owner FSM (registered):
- **OWN_CORE**
  - If `m0_req_i` = 1: route m0 and set `hold_o` = 1 (fetch stalled).
  - Else: route m1 and set `hold_o` = 0.
  - If `m2_req_i` = 1: go to OWN_HANDOVER and load the counter with `HANDOVER_CYCLES`-1.
- **OWN_HANDOVER**
  - `hold_o` = 1, nothing routed, all slave `we` = 0.
  - Counter decrements each cycle.
  - At 0, go to OWN_DBG.
  - If `m2_req_i` drops, go to OWN_RETURN (abort).
- **OWN_DBG**
  - Route m2, with `m2_gnt_o` = 1 and `hold_o` = 1.
  - When `m2_req_i` = 0, go to OWN_RETURN.
- **OWN_RETURN**
  - `hold_o` = 1, nothing routed.
  - Next state is OWN_HANDOVER if `m2_req_i` = 1 (counter reloaded), else OWN_CORE.

Boundary cases:
- **m2 and m0 request in the same cycle while in OWN_CORE:** m0 is served that cycle; handover starts next cycle.
- **Reset:**
  - `rst` forces OWN_CORE and clears the counter.
  - While `rst` = 1, all outputs read 0: all `we` = 0, `hold_o` = 0, `m2_gnt_o` = 0, `dec_err_o` = 0, all rdata = 0.
  - An `m2_req_i` held through reset is sampled in the first cycle after reset.
- **Debug writes:** never reach a slave outside OWN_DBG.

## Timing

- Routing, rdata, `we_o`, `hold_o` and `dec_err_o` are combinational from the registered state plus the current inputs.
- Slaves have combinational read and write on the `clk` edge; the read latency seen by masters is 0 cycles.
- Debug access latency, from an `m2_req_i` rise (sampled in OWN_CORE) to `m2_gnt_o` = 1:
  - 1 cycle to enter OWN_HANDOVER.
  - `HANDOVER_CYCLES` cycles in OWN_HANDOVER.
  - Total: `HANDOVER_CYCLES`+1 cycles.
- Release: 1 cycle after `m2_req_i` falls, in OWN_RETURN; the core resumes the following cycle.
- The debug port must hold `m2_req_i`, addr and data stable until it observes `m2_gnt_o`.

## Structure

- `defines.v` holds:
  - Owner-state encodings `OWN_CORE`/`OWN_HANDOVER`/`OWN_DBG`/`OWN_RETURN` (2 bits).
  - Region nibbles `SLV_ROM` = 4'h0 and `SLV_RAM` = 4'h1.
- One sub-module, `bus_addr_dec`: combinational; maps addr to the s0/s1/none one-hot. Instantiated once on the routed address.
- Top-level integration: connect m2 to the jtag_top `mem_*`/`op_req_o` signals, and `hold_o` to the core's hold input.

## Test plan

- **Idle core:** `m0_req_i` = 0, `m1_addr_i` = 0x0000_0010, s0 returns 0x0000_0013 → `m1_rdata_o` = 0x0000_0013, `hold_o` = 0, `s0_we_o` = 0.
- **Core write:** `m0_req_i` = 1, `m0_we_i` = 1, addr 0x1000_0004, wdata 0xDEAD_BEEF → `s1_we_o` = 1 with that data, `s0_we_o` = 0, `hold_o` = 1.
- **Debug handover:** `HANDOVER_CYCLES` = 2; raise `m2_req_i` in cycle N → `hold_o` = 1 from N+1, `m2_gnt_o` = 1 at N+3. Debug write to 0x1000_0000 occurs only at N+3.
- **Abort and release:**
  - Drop `m2_req_i` at N+2 → OWN_RETURN at N+3, OWN_CORE at N+4 with `hold_o` following `m0_req_i`.
  - Same check after a normal DBG release.
- **Unmapped access:** m0 read from 0x2000_0000 → `m0_rdata_o` = 0, `dec_err_o` pulses 1 cycle, both `we` = 0.
- **Reset mid-debug:** assert `rst` during OWN_DBG → next cycle OWN_CORE, all outputs 0 during reset. With `m2_req_i` still high, `m2_gnt_o` returns `HANDOVER_CYCLES`+1 cycles after reset release.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the SoC bus arbiter: owner states,
// slave region nibbles, routed-master selector and slave one-hot select.
package bus_arbiter_pkg;

  // Bus owner states
  typedef enum logic [1:0] {
    OWN_CORE     = 2'd0,
    OWN_HANDOVER = 2'd1,
    OWN_DBG      = 2'd2,
    OWN_RETURN   = 2'd3
  } own_state_e;

  // Region nibbles taken from the top four address bits
  localparam logic [3:0] SLV_ROM = 4'h0;
  localparam logic [3:0] SLV_RAM = 4'h1;

  // Which master drives the slaves this cycle
  typedef enum logic [1:0] {
    MSTR_NONE = 2'd0,
    MSTR_M0   = 2'd1,
    MSTR_M1   = 2'd2,
    MSTR_M2   = 2'd3
  } mstr_e;

  // One-hot slave select produced by the address decoder
  typedef struct packed {
    logic none;
    logic s1;
    logic s0;
  } slv_sel_t;

endpackage

// File: rtl/bus_addr_dec.sv
// Address region decoder: maps the top address nibble to a one-hot
// rom / ram / unmapped select.
module bus_addr_dec
  import bus_arbiter_pkg::*;
(
  input  logic [3:0] i_region,
  output slv_sel_t   o_sel
);

  // Decode the region nibble; anything outside rom/ram is unmapped
  always_comb begin
    o_sel = '0;
    case (i_region)
      SLV_ROM: o_sel.s0   = 1'b1;
      SLV_RAM: o_sel.s1   = 1'b1;
      default: o_sel.none = 1'b1;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Three-master / two-slave bus arbiter. The core data port has priority
// over instruction fetch; the debug port takes the bus only after a
// drained handover during which nothing is routed and the core is held.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int HANDOVER_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  // core data port
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  // core fetch port
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  // debug port
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_wdata_i,
  output logic [DATA_W-1:0] m2_rdata_o,
  input  logic              m2_req_i,
  input  logic              m2_we_i,
  output logic              m2_gnt_o,
  // rom
  output logic [ADDR_W-1:0] s0_addr_o,
  output logic [DATA_W-1:0] s0_data_o,
  input  logic [DATA_W-1:0] s0_data_i,
  output logic              s0_we_o,
  // ram
  output logic [ADDR_W-1:0] s1_addr_o,
  output logic [DATA_W-1:0] s1_data_o,
  input  logic [DATA_W-1:0] s1_data_i,
  output logic              s1_we_o,
  // core stall and decode error
  output logic              hold_o,
  output logic              dec_err_o
);

  localparam logic [3:0] HC_LOAD = 4'(HANDOVER_CYCLES - 1);

  own_state_e        r_state;
  own_state_e        w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;

  mstr_e             w_mstr;
  logic              w_hold;
  logic              w_gnt;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic              w_access;
  logic [DATA_W-1:0] w_rdata;
  slv_sel_t          w_sel;

  // Owner state and handover counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OWN_CORE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next owner: an abort during handover wins over the counter expiring
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      OWN_CORE: begin
        if (m2_req_i) begin
          w_state_next = OWN_HANDOVER;
          w_cnt_next   = HC_LOAD;
        end
      end
      OWN_HANDOVER: begin
        if (!m2_req_i) begin
          w_state_next = OWN_RETURN;
        end else if (r_cnt == 4'd0) begin
          w_state_next = OWN_DBG;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      OWN_DBG: begin
        if (!m2_req_i) begin
          w_state_next = OWN_RETURN;
        end
      end
      OWN_RETURN: begin
        if (m2_req_i) begin
          w_state_next = OWN_HANDOVER;
          w_cnt_next   = HC_LOAD;
        end else begin
          w_state_next = OWN_CORE;
        end
      end
      default: w_state_next = OWN_CORE;
    endcase
  end

  // Per-state routing choice, core hold and debug grant
  always_comb begin
    w_mstr = MSTR_NONE;
    w_hold = 1'b1;
    w_gnt  = 1'b0;
    case (r_state)
      OWN_CORE: begin
        w_mstr = m0_req_i ? MSTR_M0 : MSTR_M1;
        w_hold = m0_req_i;
      end
      OWN_DBG: begin
        w_mstr = MSTR_M2;
        w_gnt  = 1'b1;
      end
      default: begin
        w_mstr = MSTR_NONE;
        w_hold = 1'b1;
      end
    endcase
  end

  // Select the routed master's address, write data and write enable;
  // a debug write is only honoured while the request is still asserted
  always_comb begin
    w_addr   = '0;
    w_wdata  = '0;
    w_we     = 1'b0;
    w_access = 1'b0;
    case (w_mstr)
      MSTR_M0: begin
        w_addr   = m0_addr_i;
        w_wdata  = m0_wdata_i;
        w_we     = m0_we_i;
        w_access = 1'b1;
      end
      MSTR_M1: begin
        w_addr   = m1_addr_i;
        w_access = 1'b1;
      end
      MSTR_M2: begin
        w_addr   = m2_addr_i;
        w_wdata  = m2_wdata_i;
        w_we     = m2_we_i & m2_req_i;
        w_access = m2_req_i;
      end
      default: ;
    endcase
  end

  bus_addr_dec u_dec (
    .i_region (w_addr[ADDR_W-1 -: 4]),
    .o_sel    (w_sel)
  );

  assign w_rdata = w_sel.s0 ? s0_data_i :
                   w_sel.s1 ? s1_data_i : '0;

  // Everything reads zero while reset is held
  assign s0_addr_o  = rst ? '0 : w_addr;
  assign s1_addr_o  = rst ? '0 : w_addr;
  assign s0_data_o  = rst ? '0 : w_wdata;
  assign s1_data_o  = rst ? '0 : w_wdata;
  assign s0_we_o    = !rst && w_we && w_sel.s0;
  assign s1_we_o    = !rst && w_we && w_sel.s1;
  assign hold_o     = !rst && w_hold;
  assign m2_gnt_o   = !rst && w_gnt;
  assign dec_err_o  = !rst && w_access && w_sel.none;
  assign m0_rdata_o = (!rst && w_mstr == MSTR_M0) ? w_rdata : '0;
  assign m1_rdata_o = (!rst && w_mstr == MSTR_M1) ? w_rdata : '0;
  assign m2_rdata_o = (!rst && w_mstr == MSTR_M2) ? w_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: each scenario drives one step per
// cycle, pushes the expected outputs to a scoreboard queue and pops and
// compares them against the DUT on the falling edge.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic        m0_req_i, m0_we_i;
  logic [31:0] m1_addr_i, m1_rdata_o;
  logic [31:0] m2_addr_i, m2_wdata_i, m2_rdata_o;
  logic        m2_req_i, m2_we_i, m2_gnt_o;
  logic [31:0] s0_addr_o, s0_data_o, s0_data_i;
  logic        s0_we_o;
  logic [31:0] s1_addr_o, s1_data_o, s1_data_i;
  logic        s1_we_o;
  logic        hold_o, dec_err_o;

  int passed = 0;
  int checks = 0;

  typedef struct packed {
    logic        hold;
    logic        gnt;
    logic        err;
    logic        we0;
    logic        we1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] a0;
    logic [31:0] a1;
  } obs_t;

  obs_t exp_q[$];

  localparam logic [31:0] ROM_D = 32'h0000_0013;
  localparam logic [31:0] RAM_D = 32'h0000_0055;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .HANDOVER_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i),
    .m1_addr_i(m1_addr_i), .m1_rdata_o(m1_rdata_o),
    .m2_addr_i(m2_addr_i), .m2_wdata_i(m2_wdata_i), .m2_rdata_o(m2_rdata_o),
    .m2_req_i(m2_req_i), .m2_we_i(m2_we_i), .m2_gnt_o(m2_gnt_o),
    .s0_addr_o(s0_addr_o), .s0_data_o(s0_data_o), .s0_data_i(s0_data_i), .s0_we_o(s0_we_o),
    .s1_addr_o(s1_addr_o), .s1_data_o(s1_data_o), .s1_data_i(s1_data_i), .s1_we_o(s1_we_o),
    .hold_o(hold_o), .dec_err_o(dec_err_o)
  );

  // Expected output bundle; both slaves always see the same addr/data
  function automatic obs_t mk(input logic hold, input logic gnt, input logic err,
                              input logic we0, input logic we1,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic [31:0] rd2, input logic [31:0] d,
                              input logic [31:0] a);
    obs_t o;
    o.hold = hold; o.gnt = gnt; o.err = err; o.we0 = we0; o.we1 = we1;
    o.rd0 = rd0; o.rd1 = rd1; o.rd2 = rd2;
    o.d0 = d; o.d1 = d; o.a0 = a; o.a1 = a;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.hold = hold_o; o.gnt = m2_gnt_o; o.err = dec_err_o;
    o.we0 = s0_we_o; o.we1 = s1_we_o;
    o.rd0 = m0_rdata_o; o.rd1 = m1_rdata_o; o.rd2 = m2_rdata_o;
    o.d0 = s0_data_o; o.d1 = s1_data_o; o.a0 = s0_addr_o; o.a1 = s1_addr_o;
    return o;
  endfunction

  task automatic drive(input logic r, input logic m0r, input logic m0w,
                       input logic [31:0] m0a, input logic [31:0] m0d,
                       input logic [31:0] m1a, input logic m2r, input logic m2w,
                       input logic [31:0] m2a, input logic [31:0] m2d);
    rst = r;
    m0_req_i = m0r; m0_we_i = m0w; m0_addr_i = m0a; m0_wdata_i = m0d;
    m1_addr_i = m1a;
    m2_req_i = m2r; m2_we_i = m2w; m2_addr_i = m2a; m2_wdata_i = m2d;
  endtask

  task automatic test_reset();
    obs_t got, want;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      case (i)
        0, 1: begin
          drive(1, 1, 1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h10, 1, 1, 32'h1000_0000, 32'h1);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        default: begin
          drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 0));
        end
      endcase
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      else begin passed++; $display("txn reset[%0d] ok %h", i, got); end
    end
  endtask

  task automatic test_idle_core();
    obs_t got, want;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        drive(0, 0, 0, 0, 0, 32'h0000_0010, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h0000_0010));
      end else begin
        drive(0, 0, 0, 0, 0, 32'h1000_0020, 0, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, RAM_D, 0, 0, 32'h1000_0020));
      end
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL idle[%0d] got=%h want=%h", i, got, want);
      else begin passed++; $display("txn idle[%0d] ok %h", i, got); end
    end
  endtask

  task automatic test_core_write();
    obs_t got, want;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin
          drive(0, 1, 1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(1, 0, 0, 0, 1, RAM_D, 0, 0, 32'hDEAD_BEEF, 32'h1000_0004));
        end
        1: begin
          drive(0, 1, 0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(1, 0, 0, 0, 0, ROM_D, 0, 0, 32'hDEAD_BEEF, 32'h0000_0008));
        end
        default: begin
          drive(0, 1, 1, 32'h0000_000C, 32'hDEAD_BEEF, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(1, 0, 0, 1, 0, ROM_D, 0, 0, 32'hDEAD_BEEF, 32'h0000_000C));
        end
      endcase
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL core_write[%0d] got=%h want=%h", i, got, want);
      else begin passed++; $display("txn core_write[%0d] ok %h", i, got); end
    end
  endtask

  task automatic test_unmapped();
    obs_t got, want;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin
          drive(0, 1, 0, 32'h2000_0000, 32'h0, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h2000_0000));
        end
        1: begin
          drive(0, 1, 1, 32'h3000_0000, 32'h77, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 32'h77, 32'h3000_0000));
        end
        default: begin
          drive(0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
        end
      endcase
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL unmapped[%0d] got=%h want=%h", i, got, want);
      else begin passed++; $display("txn unmapped[%0d] ok %h", i, got); end
    end
  endtask

  // Request at step 0 (N); grant at N+3; release at N+4; core back at N+6
  task automatic test_handover();
    obs_t got, want;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin
          drive(0, 0, 0, 0, 0, 32'h10, 1, 1, 32'h1000_0000, 32'hCAFE_0001);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
        end
        1, 2: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        3: exp_q.push_back(mk(1, 1, 0, 0, 1, 0, 0, RAM_D, 32'hCAFE_0001, 32'h1000_0000));
        4: begin
          drive(0, 0, 0, 0, 0, 32'h10, 0, 0, 32'h1000_0000, 32'hCAFE_0001);
          exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, RAM_D, 32'hCAFE_0001, 32'h1000_0000));
        end
        5: begin
          drive(0, 1, 0, 32'h4, 0, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        6: exp_q.push_back(mk(1, 0, 0, 0, 0, ROM_D, 0, 0, 0, 32'h4));
        default: begin
          drive(0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
        end
      endcase
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL handover[%0d] got=%h want=%h", i, got, want);
      else begin passed++; $display("txn handover[%0d] ok %h", i, got); end
    end
  endtask

  // Request dropped at N+2: return at N+3, core at N+4 following m0_req
  task automatic test_abort();
    obs_t got, want;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin
          drive(0, 0, 0, 0, 0, 32'h10, 1, 1, 32'h1000_0000, 32'hCAFE_0002);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
        end
        1: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        2: begin
          drive(0, 0, 0, 0, 0, 32'h10, 0, 1, 32'h1000_0000, 32'hCAFE_0002);
          exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        3: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        4: begin
          drive(0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
        end
        default: begin
          drive(0, 1, 0, 32'h1000_0000, 0, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(1, 0, 0, 0, 0, RAM_D, 0, 0, 0, 32'h1000_0000));
        end
      endcase
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL abort[%0d] got=%h want=%h", i, got, want);
      else begin passed++; $display("txn abort[%0d] ok %h", i, got); end
    end
  endtask

  // m0 and m2 together: m0 served first, then handover blocks m0
  task automatic test_same_cycle();
    obs_t got, want;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin
          drive(0, 1, 1, 32'h1000_0008, 32'h11, 32'h10, 1, 1, 32'h1000_0000, 32'h22);
          exp_q.push_back(mk(1, 0, 0, 0, 1, RAM_D, 0, 0, 32'h11, 32'h1000_0008));
        end
        1: begin
          drive(0, 1, 1, 32'h1000_0008, 32'h11, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        2: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        3: exp_q.push_back(mk(1, 0, 0, 0, 1, RAM_D, 0, 0, 32'h11, 32'h1000_0008));
        default: begin
          drive(0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
        end
      endcase
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL same_cycle[%0d] got=%h want=%h", i, got, want);
      else begin passed++; $display("txn same_cycle[%0d] ok %h", i, got); end
    end
  endtask

  // Reset during debug ownership; m2_req held through reset regains the
  // bus three cycles after release
  task automatic test_reset_mid_debug();
    obs_t got, want;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin
          drive(0, 0, 0, 0, 0, 32'h10, 1, 0, 32'h0, 32'h99);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
        end
        1, 2, 7, 8, 11: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        3, 9: exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, ROM_D, 32'h99, 0));
        4, 5: begin
          drive(1, 0, 0, 0, 0, 32'h10, 1, 0, 32'h0, 32'h99);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        6: begin
          drive(0, 0, 0, 0, 0, 32'h10, 1, 0, 32'h0, 32'h99);
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
        end
        10: begin
          drive(0, 0, 0, 0, 0, 32'h10, 0, 0, 32'h0, 32'h99);
          exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, ROM_D, 32'h99, 0));
        end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, ROM_D, 0, 0, 32'h10));
      endcase
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL rst_mid_dbg[%0d] got=%h want=%h", i, got, want);
      else begin passed++; $display("txn rst_mid_dbg[%0d] ok %h", i, got); end
    end
  endtask

  initial begin
    s0_data_i = ROM_D;
    s1_data_i = RAM_D;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    test_reset();
    test_idle_core();
    test_core_write();
    test_unmapped();
    test_handover();
    test_abort();
    test_same_cycle();
    test_reset_mid_debug();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
